alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle for alu_pipe.
// The master drives operands and out_ready; the slave (the ALU) returns results and flags.
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OpCode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;

    modport master (
        output in_valid, A, B, OpCode, out_ready,
        input  in_ready, out_valid, Result, N, Z, C, V
    );

    modport slave (
        input  in_valid, A, B, OpCode, out_ready,
        output in_ready, out_valid, Result, N, Z, C, V
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, NZCV flags and a carry register for ADC chains.
// Define ALU_PIPE_OUT_REG_EN to add a second output register stage (latency 2 instead of 1).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ADC = 3'b111
    } op_e;

    op_e              op;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_cy_upd;
    logic             accept;
    logic             s1_drain;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_res_q, s1_res_d;
    logic [3:0]       s1_flags_q, s1_flags_d;
    logic             cy_q, cy_d;

    assign op = op_e'(bus.OpCode);

    always_comb begin
        alu_sum    = '0;
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_cy_upd = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_sum    = {1'b0, bus.A} + {1'b0, bus.B}
                           + {{WIDTH{1'b0}}, (op == OP_ADC) ? cy_q : 1'b0};
                alu_res    = alu_sum[WIDTH-1:0];
                alu_c      = alu_sum[WIDTH];
                alu_v      = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                             (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
                alu_cy_upd = 1'b1;
            end
            OP_SUB: begin
                // C = 1 means no borrow (A >= B unsigned)
                alu_sum    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
                alu_res    = alu_sum[WIDTH-1:0];
                alu_c      = alu_sum[WIDTH];
                alu_v      = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                             (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
                alu_cy_upd = 1'b1;
            end
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_SHL: begin
                alu_res    = {bus.A[WIDTH-2:0], 1'b0};
                alu_c      = bus.A[WIDTH-1];
                alu_cy_upd = 1'b1;
            end
            OP_SHR: begin
                alu_res    = {1'b0, bus.A[WIDTH-1:1]};
                alu_c      = bus.A[0];
                alu_cy_upd = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;

    // Stage 1 also owns the carry register, so ADC chains behave the same in both builds.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_flags_d = s1_flags_q;
        cy_d       = cy_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_res_d   = alu_res;
            s1_flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            if (alu_cy_upd) begin
                cy_d = alu_c;
            end
        end else if (s1_drain) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_flags_q <= '0;
            cy_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_flags_q <= s1_flags_d;
            cy_q       <= cy_d;
        end
    end

`ifdef ALU_PIPE_OUT_REG_EN
    logic             s2_ready;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [3:0]       s2_flags_q, s2_flags_d;

    assign s2_ready     = !s2_valid_q || bus.out_ready;
    assign s1_drain     = s1_valid_q && s2_ready;
    assign bus.in_ready = !s1_valid_q || s2_ready;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        if (s1_drain) begin
            s2_valid_d = 1'b1;
            s2_res_d   = s1_res_q;
            s2_flags_d = s1_flags_q;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign bus.out_valid                 = s2_valid_q;
    assign bus.Result                    = s2_res_q;
    assign {bus.N, bus.Z, bus.C, bus.V}  = s2_flags_q;
`else
    assign s1_drain     = s1_valid_q && bus.out_ready;
    assign bus.in_ready = !s1_valid_q || bus.out_ready;

    assign bus.out_valid                 = s1_valid_q;
    assign bus.Result                    = s1_res_q;
    assign {bus.N, bus.Z, bus.C, bus.V}  = s1_flags_q;
`endif
endmodule
